// File: rtl/dram_port_arbiter_if.sv
// Request/DRAM command bundle between the requesters, the port arbiter and the DRAM interface.
interface dram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 8
);
    logic [2:0]          req_valid;
    logic [3*ADDR_W-1:0] req_addr;
    logic [3*LEN_W-1:0]  req_len;
    logic [2:0]          req_ready;
    logic [2:0]          req_done;
    logic                dram_cmd_valid;
    logic                dram_cmd_ready;
    logic                dram_cmd_we;
    logic [ADDR_W-1:0]   dram_cmd_addr;
    logic                busy;
    logic [1:0]          grant_id;

    modport master (
        output req_valid, req_addr, req_len, dram_cmd_ready,
        input  req_ready, req_done, dram_cmd_valid, dram_cmd_we, dram_cmd_addr, busy, grant_id
    );

    modport slave (
        input  req_valid, req_addr, req_len, dram_cmd_ready,
        output req_ready, req_done, dram_cmd_valid, dram_cmd_we, dram_cmd_addr, busy, grant_id
    );
endinterface

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing one DRAM command port between tbuf load, wbuf load and
// tbuf writeback; each grant is expanded into a burst of per-beat commands.
module dram_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned BEAT_BYTES = 64
) (
    input logic                clk,
    input logic                rst_n,
    dram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_rr_ptr, w_rr_ptr_nxt;
    logic [1:0]        r_id, w_id_nxt;
    logic [LEN_W-1:0]  r_len, w_len_nxt;
    logic [LEN_W-1:0]  r_beat, w_beat_nxt;
    logic [2:0]        r_req_ready, w_req_ready_nxt;
    logic [2:0]        r_req_done, w_req_done_nxt;
    logic              r_cmd_valid, w_cmd_valid_nxt;
    logic              r_cmd_we, w_cmd_we_nxt;
    logic [ADDR_W-1:0] r_cmd_addr, w_cmd_addr_nxt;
    logic              r_busy, w_busy_nxt;
    logic [1:0]        r_grant_id, w_grant_id_nxt;

    logic [2:0]        w_rot;
    logic [1:0]        w_off;
    logic [2:0]        w_sum;
    logic [1:0]        w_pick;
    logic              w_found;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [LEN_W-1:0]  w_sel_len;

    function automatic logic [2:0] onehot3(input logic [1:0] id);
        case (id)
            2'd1:    onehot3 = 3'b010;
            2'd2:    onehot3 = 3'b100;
            default: onehot3 = 3'b001;
        endcase
    endfunction

    // Rotate requests so bit 0 is the round-robin head, then map the winner back to its id.
    always_comb begin
        case (r_rr_ptr)
            2'd1:    w_rot = {bus.req_valid[0], bus.req_valid[2], bus.req_valid[1]};
            2'd2:    w_rot = {bus.req_valid[1], bus.req_valid[0], bus.req_valid[2]};
            default: w_rot = bus.req_valid;
        endcase
        w_found = |bus.req_valid;
        w_off   = w_rot[0] ? 2'd0 : (w_rot[1] ? 2'd1 : 2'd2);
        w_sum   = {1'b0, r_rr_ptr} + {1'b0, w_off};
        w_pick  = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
        case (w_pick)
            2'd1: begin
                w_sel_addr = bus.req_addr[ADDR_W +: ADDR_W];
                w_sel_len  = bus.req_len[LEN_W +: LEN_W];
            end
            2'd2: begin
                w_sel_addr = bus.req_addr[2*ADDR_W +: ADDR_W];
                w_sel_len  = bus.req_len[2*LEN_W +: LEN_W];
            end
            default: begin
                w_sel_addr = bus.req_addr[0 +: ADDR_W];
                w_sel_len  = bus.req_len[0 +: LEN_W];
            end
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_id_nxt        = r_id;
        w_len_nxt       = r_len;
        w_beat_nxt      = r_beat;
        w_req_ready_nxt = 3'b000;
        w_req_done_nxt  = 3'b000;
        w_cmd_valid_nxt = r_cmd_valid;
        w_cmd_we_nxt    = r_cmd_we;
        w_cmd_addr_nxt  = r_cmd_addr;
        w_grant_id_nxt  = r_grant_id;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_id_nxt        = w_pick;
                    w_grant_id_nxt  = w_pick;
                    w_req_ready_nxt = onehot3(w_pick);
                    w_rr_ptr_nxt    = (w_pick == 2'd2) ? 2'd0 : w_pick + 2'd1;
                    w_len_nxt       = w_sel_len;
                    w_beat_nxt      = '0;
                    w_cmd_addr_nxt  = w_sel_addr;
                    w_cmd_we_nxt    = (w_pick == 2'd2);
                    if (w_sel_len != '0) begin
                        w_state_nxt     = ST_BURST;
                        w_cmd_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_BURST: begin
                if (r_cmd_valid && bus.dram_cmd_ready) begin
                    if (r_beat == LEN_W'(r_len - LEN_W'(1))) begin
                        w_state_nxt     = ST_DONE;
                        w_cmd_valid_nxt = 1'b0;
                    end else begin
                        w_beat_nxt     = r_beat + LEN_W'(1);
                        w_cmd_addr_nxt = r_cmd_addr + ADDR_W'(BEAT_BYTES);
                    end
                end
            end
            ST_DONE: begin
                w_req_done_nxt = onehot3(r_id);
                w_state_nxt    = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // The done pulse lands in the cycle after DONE, so busy is stretched to cover it.
        w_busy_nxt = (w_state_nxt != ST_IDLE) || (r_state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= 2'd0;
            r_id        <= 2'd0;
            r_len       <= '0;
            r_beat      <= '0;
            r_req_ready <= 3'b000;
            r_req_done  <= 3'b000;
            r_cmd_valid <= 1'b0;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= '0;
            r_busy      <= 1'b0;
            r_grant_id  <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_id        <= w_id_nxt;
            r_len       <= w_len_nxt;
            r_beat      <= w_beat_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_req_done  <= w_req_done_nxt;
            r_cmd_valid <= w_cmd_valid_nxt;
            r_cmd_we    <= w_cmd_we_nxt;
            r_cmd_addr  <= w_cmd_addr_nxt;
            r_busy      <= w_busy_nxt;
            r_grant_id  <= w_grant_id_nxt;
        end
    end

    assign bus.req_ready      = r_req_ready;
    assign bus.req_done       = r_req_done;
    assign bus.dram_cmd_valid = r_cmd_valid;
    assign bus.dram_cmd_we    = r_cmd_we;
    assign bus.dram_cmd_addr  = r_cmd_addr;
    assign bus.busy           = r_busy;
    assign bus.grant_id       = r_grant_id;
endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter: scoreboard queues of expected grants, beats and
// done pulses, popped by a negedge monitor as the DUT produces them.
module tb_dram_port_arbiter;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned LEN_W      = 8;
    localparam int unsigned BEAT_BYTES = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dram_port_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    dram_port_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .BEAT_BYTES(BEAT_BYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W:0] exp_cmd_q[$];   // {we, addr}
    logic [1:0]      exp_grant_q[$];
    logic [1:0]      exp_done_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] oh(input logic [1:0] id);
        logic [2:0] v;
        v = 3'b000;
        v[id] = 1'b1;
        return v;
    endfunction

    // Monitor: pops scoreboard entries on grants, accepted beats and done pulses.
    logic              prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr  = '0;
    logic              prev_we    = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(bus.dram_cmd_valid), 64'(1));
                chk("hold_addr", 64'(bus.dram_cmd_addr), 64'(prev_addr));
                chk("hold_we", 64'(bus.dram_cmd_we), 64'(prev_we));
            end
            if (bus.req_ready != 3'b000) begin
                chk("grant_expected", 64'(exp_grant_q.size() != 0), 64'(1));
                if (exp_grant_q.size() != 0) begin
                    logic [1:0] g;
                    g = exp_grant_q.pop_front();
                    chk("grant_ready", 64'(bus.req_ready), 64'(oh(g)));
                    chk("grant_id", 64'(bus.grant_id), 64'(g));
                end
            end
            if (bus.dram_cmd_valid && bus.dram_cmd_ready) begin
                chk("cmd_expected", 64'(exp_cmd_q.size() != 0), 64'(1));
                if (exp_cmd_q.size() != 0) begin
                    logic [ADDR_W:0] e;
                    e = exp_cmd_q.pop_front();
                    chk("cmd_addr", 64'(bus.dram_cmd_addr), 64'(e[ADDR_W-1:0]));
                    chk("cmd_we", 64'(bus.dram_cmd_we), 64'(e[ADDR_W]));
                end
            end
            if (bus.req_done != 3'b000) begin
                chk("done_expected", 64'(exp_done_q.size() != 0), 64'(1));
                if (exp_done_q.size() != 0) begin
                    logic [1:0] d;
                    d = exp_done_q.pop_front();
                    chk("done_onehot", 64'(bus.req_done), 64'(oh(d)));
                    chk("done_busy", 64'(bus.busy), 64'(1));
                end
            end
            prev_stall = bus.dram_cmd_valid && !bus.dram_cmd_ready;
            prev_addr  = bus.dram_cmd_addr;
            prev_we    = bus.dram_cmd_we;
        end
    end

    task automatic chk_all_zero(input string p);
        chk({p, "_ready"}, 64'(bus.req_ready), 64'(0));
        chk({p, "_done"}, 64'(bus.req_done), 64'(0));
        chk({p, "_valid"}, 64'(bus.dram_cmd_valid), 64'(0));
        chk({p, "_we"}, 64'(bus.dram_cmd_we), 64'(0));
        chk({p, "_addr"}, 64'(bus.dram_cmd_addr), 64'(0));
        chk({p, "_busy"}, 64'(bus.busy), 64'(0));
        chk({p, "_gid"}, 64'(bus.grant_id), 64'(0));
    endtask

    task automatic set_req(input int id, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        case (id)
            1: begin bus.req_addr[ADDR_W +: ADDR_W] = a; bus.req_len[LEN_W +: LEN_W] = l; end
            2: begin bus.req_addr[2*ADDR_W +: ADDR_W] = a; bus.req_len[2*LEN_W +: LEN_W] = l; end
            default: begin bus.req_addr[0 +: ADDR_W] = a; bus.req_len[0 +: LEN_W] = l; end
        endcase
    endtask

    task automatic push_burst(input logic [1:0] id, input logic [ADDR_W-1:0] a, input int len);
        exp_grant_q.push_back(id);
        for (int b = 0; b < len; b++)
            exp_cmd_q.push_back({(id == 2'd2), ADDR_W'(a + ADDR_W'(b * BEAT_BYTES))});
        exp_done_q.push_back(id);
    endtask

    task automatic wait_grant(input string tag, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (bus.req_ready == 3'b000 && cyc < 20);
        chk(tag, 64'(bus.req_ready != 3'b000), 64'(1));
    endtask

    task automatic wait_quiet(input string tag);
        int c;
        c = 0;
        while ((exp_done_q.size() != 0 || bus.busy) && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        chk(tag, 64'(c < 200), 64'(1));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1 chk_all_zero("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int cyc;
        bus.req_valid      = 3'b000;
        bus.req_addr       = '0;
        bus.req_len        = '0;
        bus.dram_cmd_ready = 1'b1;
        #2 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("post_reset");

        // Single len-4 read burst.
        set_req(0, 32'h0000_1000, 8'd4);
        push_burst(2'd0, 32'h0000_1000, 4);
        bus.req_valid = 3'b001;
        wait_grant("t1_grant", cyc);
        bus.req_valid = 3'b000;
        chk("t1_latency", 64'(cyc), 64'(1));
        chk("t1_valid_with_grant", 64'(bus.dram_cmd_valid), 64'(1));
        chk("t1_busy", 64'(bus.busy), 64'(1));
        wait_quiet("t1_quiet");

        // Round-robin from reset with all three requesting.
        do_reset();
        set_req(0, 32'h0000_0100, 8'd1);
        set_req(1, 32'h0000_0200, 8'd1);
        set_req(2, 32'h0000_0300, 8'd1);
        push_burst(2'd0, 32'h0000_0100, 1);
        push_burst(2'd1, 32'h0000_0200, 1);
        push_burst(2'd2, 32'h0000_0300, 1);
        push_burst(2'd0, 32'h0000_0100, 1);
        bus.req_valid = 3'b111;
        for (int g = 0; g < 4; g++) begin
            wait_grant("t2_grant", cyc);
            if (g == 3) bus.req_valid = 3'b000;
        end
        wait_quiet("t2_quiet");

        // Write burst with command back-pressure.
        bus.dram_cmd_ready = 1'b0;
        set_req(2, 32'h0000_2000, 8'd2);
        push_burst(2'd2, 32'h0000_2000, 2);
        bus.req_valid = 3'b100;
        wait_grant("t3_grant", cyc);
        bus.req_valid = 3'b000;
        for (int i = 0; i < 4; i++) begin
            chk("t3_hold_addr", 64'(bus.dram_cmd_addr), 64'(32'h0000_2000));
            chk("t3_hold_we", 64'(bus.dram_cmd_we), 64'(1));
            if (i == 3) bus.dram_cmd_ready = 1'b1;
            @(posedge clk); #1;
        end
        chk("t3_second_addr", 64'(bus.dram_cmd_addr), 64'(32'h0000_2040));
        chk("t3_second_valid", 64'(bus.dram_cmd_valid), 64'(1));
        wait_quiet("t3_quiet");

        // Zero-length request: grant, done, no DRAM command.
        set_req(1, 32'h0000_3000, 8'd0);
        exp_grant_q.push_back(2'd1);
        exp_done_q.push_back(2'd1);
        bus.req_valid = 3'b010;
        wait_grant("t4_grant", cyc);
        bus.req_valid = 3'b000;
        chk("t4_busy1", 64'(bus.busy), 64'(1));
        chk("t4_novalid1", 64'(bus.dram_cmd_valid), 64'(0));
        chk("t4_nodone1", 64'(bus.req_done), 64'(0));
        @(posedge clk); #1;
        chk("t4_done", 64'(bus.req_done), 64'(3'b010));
        chk("t4_busy2", 64'(bus.busy), 64'(1));
        chk("t4_novalid2", 64'(bus.dram_cmd_valid), 64'(0));
        @(posedge clk); #1;
        chk("t4_idle", 64'(bus.busy), 64'(0));
        wait_quiet("t4_quiet");

        // Address wrap at the top of the address space.
        set_req(0, 32'hFFFF_FFC0, 8'd2);
        push_burst(2'd0, 32'hFFFF_FFC0, 2);
        bus.req_valid = 3'b001;
        wait_grant("t5_grant", cyc);
        bus.req_valid = 3'b000;
        wait_quiet("t5_quiet");

        // Reset during beat 2 of a len-4 burst, then rr pointer restarts at id0.
        set_req(0, 32'h0000_4000, 8'd4);
        exp_grant_q.push_back(2'd0);
        exp_cmd_q.push_back({1'b0, 32'h0000_4000});
        exp_cmd_q.push_back({1'b0, 32'h0000_4040});
        bus.req_valid = 3'b001;
        wait_grant("t6_grant", cyc);
        bus.req_valid = 3'b000;
        repeat (2) begin @(posedge clk); #1; end
        chk("t6_beat2_addr", 64'(bus.dram_cmd_addr), 64'(32'h0000_4080));
        #1 rst_n = 1'b0;
        #1 chk_all_zero("t6_async");
        chk("t6_beats_consumed", 64'(exp_cmd_q.size()), 64'(0));
        set_req(1, 32'h0000_5000, 8'd1);
        set_req(2, 32'h0000_6000, 8'd1);
        push_burst(2'd1, 32'h0000_5000, 1);
        push_burst(2'd2, 32'h0000_6000, 1);
        bus.req_valid = 3'b110;
        repeat (2) @(posedge clk);
        #1 chk_all_zero("t6_held");
        rst_n = 1'b1;
        wait_grant("t6_regrant1", cyc);
        chk("t6_regrant_latency", 64'(cyc), 64'(1));
        bus.req_valid = 3'b100;
        wait_grant("t6_regrant2", cyc);
        bus.req_valid = 3'b000;
        wait_quiet("t6_quiet");

        chk("end_grant_q", 64'(exp_grant_q.size()), 64'(0));
        chk("end_cmd_q", 64'(exp_cmd_q.size()), 64'(0));
        chk("end_done_q", 64'(exp_done_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
